// File: rtl/spi_alu_slave.sv
// SPI target: receives an 8-bit command frame {op, a, b} LSB first and returns a 4-bit ALU result LSB first.
// Define SLAVE_MISO_TRISTATE_EN to float miso outside the result window.
module spi_alu_slave (
    input  logic sclk,
    input  logic rst_n,
    input  logic cs,
    input  logic mosi,
    output logic miso
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [3:0] result_reg, result_next;
    logic       miso_reg, miso_next;

    logic [2:0] bit_idx;
    logic [7:0] frame;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [1:0] opcode;
    logic [3:0] alu_result;

    // The IDLE edge captures bit 0 while the counter still reads zero.
    assign bit_idx = (state_reg == IDLE) ? 3'd0 : cnt_reg;

    // Frame view with the bit sampled on this edge already merged in, so the
    // eighth capture can feed the ALU without waiting another edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_frame
            assign frame[gi] = (bit_idx == 3'(gi)) ? mosi : shift_reg[gi];
        end
    endgenerate

    assign op_b   = frame[2:0];
    assign op_a   = frame[5:3];
    assign opcode = frame[7:6];

    always_comb begin
        alu_result = 4'd0;
        case (opcode)
            2'b00:   alu_result = {1'b0, op_a} + {1'b0, op_b};
            2'b01:   alu_result = {1'b0, op_a} - {1'b0, op_b};
            2'b10:   alu_result = {1'b0, op_a & op_b};
            default: alu_result = {1'b0, op_a | op_b};
        endcase
    end

    always_ff @(negedge sclk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            shift_reg  <= 8'd0;
            result_reg <= 4'd0;
            miso_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            shift_reg  <= shift_next;
            result_reg <= result_next;
            miso_reg   <= miso_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        shift_next  = shift_reg;
        result_next = result_reg;
        miso_next   = miso_reg;

        if (cs) begin
            state_next  = IDLE;
            cnt_next    = 3'd0;
            shift_next  = 8'd0;
            result_next = 4'd0;
            miso_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    shift_next = frame;
                    cnt_next   = 3'd1;
                    miso_next  = 1'b0;
                    state_next = RX;
                end
                RX: begin
                    shift_next = frame;
                    if (cnt_reg == 3'd7) begin
                        result_next = alu_result;
                        miso_next   = alu_result[0];
                        cnt_next    = 3'd0;
                        state_next  = TX;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
                TX: begin
                    if (cnt_reg == 3'd3) begin
                        miso_next  = 1'b0;
                        cnt_next   = 3'd0;
                        state_next = DONE;
                    end else begin
                        miso_next = result_reg[cnt_reg[1:0] + 2'd1];
                        cnt_next  = cnt_reg + 3'd1;
                    end
                end
                DONE: begin
                    miso_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                    miso_next  = 1'b0;
                end
            endcase
        end
    end

`ifdef SLAVE_MISO_TRISTATE_EN
    assign miso = (state_reg == TX) ? miso_reg : 1'bz;
`else
    assign miso = miso_reg;
`endif

endmodule

// File: tb/tb_spi_alu_slave.sv
// Self-checking bench for spi_alu_slave: a free-running sclk, frames driven after
// rising edges, miso sampled on rising edges, expected results held in a scoreboard queue.
module tb_spi_alu_slave;

    logic sclk;
    logic rst_n;
    logic cs;
    logic mosi;
    logic miso;

`ifdef SLAVE_MISO_TRISTATE_EN
    localparam logic IDLE_VAL = 1'bz;
`else
    localparam logic IDLE_VAL = 1'b0;
`endif

    int checks;
    int fails;
    logic [3:0] sb[$];

    spi_alu_slave dut (
        .sclk (sclk),
        .rst_n(rst_n),
        .cs   (cs),
        .mosi (mosi),
        .miso (miso)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic logic [3:0] alu_model(input logic [1:0] op, input logic [2:0] a,
                                             input logic [2:0] b);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = (int'(a) - int'(b) + 16) % 16;
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 4'(r);
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (miso !== IDLE_VAL) begin
            fails++;
            $display("FAIL %s: miso=%b expected %b", name, miso, IDLE_VAL);
        end
    endtask

    // Sends one frame, collects the four result bits and checks against the scoreboard.
    task automatic run_frame(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [3:0] want, input string name);
        logic [7:0] f;
        logic [3:0] got;
        logic [3:0] exp;
        f = {op, a, b};
        sb.push_back(want);
        for (int i = 0; i < 8; i++) begin
            @(posedge sclk); #1;
            check_idle({name, "_rx_idle"});
            cs   = 1'b0;
            mosi = f[i];
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge sclk); #1;
            got[k] = miso;
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge sclk); #1;
            check_idle({name, "_done_idle"});
        end
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: op=%0d a=%0d b=%0d result=%b expected %b", name, op, a, b, got, exp);
        end else begin
            $display("frame %s: op=%0d a=%0d b=%0d result=%b", name, op, a, b, got);
        end
        cs   = 1'b1;
        mosi = 1'b0;
        @(posedge sclk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cs    = 1'b0;
        mosi  = 1'b1;
        @(posedge sclk); #1;
        @(posedge sclk); #1;
        check_idle("reset_idle");
        rst_n = 1'b1;
        cs    = 1'b1;
        @(posedge sclk); #1;
        check_idle("reset_release_idle");
        $display("reset: miso=%b", miso);
    endtask

    task automatic test_alu;
        run_frame(2'b00, 3'd3, 3'd2, 4'd5,     "add_3_2");
        run_frame(2'b00, 3'd7, 3'd7, 4'b1110,  "add_max");
        run_frame(2'b01, 3'd1, 3'd3, 4'b1110,  "sub_wrap");
        run_frame(2'b01, 3'd5, 3'd2, 4'b0011,  "sub_5_2");
        run_frame(2'b10, 3'd6, 3'd3, 4'b0010,  "and_6_3");
        run_frame(2'b11, 3'd6, 3'd3, 4'b0111,  "or_6_3");
    endtask

    task automatic test_abort;
        logic [7:0] f;
        f = 8'b11_111_111;
        for (int i = 0; i < 5; i++) begin
            @(posedge sclk); #1;
            cs   = 1'b0;
            mosi = f[i];
        end
        @(posedge sclk); #1;
        cs = 1'b1;
        @(posedge sclk); #1;
        check_idle("abort_rx_idle");
        $display("abort in RX after 5 bits: miso=%b", miso);
        run_frame(2'b00, 3'd2, 3'd1, 4'b0011, "after_rx_abort");
        // Abort during TX: raise cs after the first result bit.
        f = {2'b00, 3'd7, 3'd7};
        for (int i = 0; i < 8; i++) begin
            @(posedge sclk); #1;
            cs   = 1'b0;
            mosi = f[i];
        end
        @(posedge sclk); #1;
        cs = 1'b1;
        @(posedge sclk); #1;
        check_idle("abort_tx_idle");
        $display("abort in TX: miso=%b", miso);
        run_frame(2'b11, 3'd4, 3'd1, 4'b0101, "after_tx_abort");
    endtask

    task automatic test_reset_in_tx;
        logic [7:0] f;
        f = {2'b00, 3'd7, 3'd7};
        for (int i = 0; i < 8; i++) begin
            @(posedge sclk); #1;
            cs   = 1'b0;
            mosi = f[i];
        end
        @(posedge sclk); #1;
        checks++;
        if (miso !== 1'b0) begin
            fails++;
            $display("FAIL rst_tx_bit0: miso=%b expected 0", miso);
        end
        @(posedge sclk); #1;
        checks++;
        if (miso !== 1'b1) begin
            fails++;
            $display("FAIL rst_tx_bit1: miso=%b expected 1", miso);
        end
        rst_n = 1'b0;
        @(posedge sclk); #1;
        check_idle("rst_tx_idle_1");
        @(posedge sclk); #1;
        check_idle("rst_tx_idle_2");
        rst_n = 1'b1;
        cs    = 1'b1;
        @(posedge sclk); #1;
        check_idle("rst_tx_release");
        $display("reset during TX: miso=%b", miso);
        run_frame(2'b01, 3'd6, 3'd1, 4'b0101, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        for (int n = 0; n < 8; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            run_frame(op, a, b, alu_model(op, a, b), $sformatf("rand_%0d", n));
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        cs     = 1'b1;
        mosi   = 1'b0;
        test_reset();
        test_alu();
        test_abort();
        test_reset_in_tx();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
